// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message scheduler: 16-word sliding window streaming W[t] over valid/ready.
// WORD_W=32 covers SHA-224/256, WORD_W=64 covers SHA-384/512. Define MSCHED_ABORT_EN to add the abort input.
module sha2_msg_scheduler #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef MSCHED_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [16*WORD_W-1:0] blk_data,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [6:0]           w_idx,
    output logic                 w_last
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
        $error("sha2_msg_scheduler: ROUNDS must be in 16..127");
    end

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] win [16];
    logic [6:0]        t;
    logic [WORD_W-1:0] w_new;
    logic              abort_req;
    logic              load;
    logic              shift;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

`ifdef MSCHED_ABORT_EN
    assign abort_req = (state == RUN) && abort;
`else
    assign abort_req = 1'b0;
`endif

    // abort wins over a simultaneous handshake: that word is treated as not consumed
    assign load  = (state == IDLE) && blk_valid;
    assign shift = (state == RUN) && w_ready && !abort_req;
    assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (blk_valid) state_nxt = RUN;
            RUN:  if (abort_req || (w_ready && t == LAST_T)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        blk_ready = (state == IDLE);
        w_valid   = (state == RUN);
        w_last    = (state == RUN) && (t == LAST_T);
    end

    // Window invariant: win[k] holds W[t+k]; t saturates at the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) win[k] <= '0;
            t <= '0;
        end else if (load) begin
            for (int k = 0; k < 16; k++) win[k] <= blk_data[(16-k)*WORD_W-1 -: WORD_W];
            t <= '0;
        end else if (abort_req) begin
            t <= '0;
        end else if (shift) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= w_new;
            if (t != LAST_T) t <= t + 7'd1;
        end
    end

    assign w_data = win[0];
    assign w_idx  = t;

endmodule
